// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scan display.
// Segment codes are active-low {g,f,e,d,c,b,a}; anodes are active-low, bit 3 = leftmost digit.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    PH_ACTIVE = 1'b0,
    PH_GUARD  = 1'b1
  } phase_e;

  // The last of every four scan phases blanks the display to suppress ghosting.
  function automatic phase_e phase_of(input logic [3:0] idx);
    return (idx[1:0] == 2'b11) ? PH_GUARD : PH_ACTIVE;
  endfunction

  function automatic logic [3:0] anode_sel(input logic [1:0] digit);
    logic [3:0] an;
    case (digit)
      2'd0:    an = 4'b0111;
      2'd1:    an = 4'b1011;
      2'd2:    an = 4'b1101;
      default: an = 4'b1110;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg_decoder (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  import seg_pkg::*;

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      default: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit 7-segment scan driver: prescaled scan counter out, nibble back from the
// character generator, registered and mutually aligned anode/segment outputs.
module seg_scan_driver #(
  parameter int PRESCALE = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] char,
  output logic [3:0] counter,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp
);
  import seg_pkg::*;

  localparam int               PRE_W    = $clog2(PRESCALE + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_cnt_p0;
  logic [3:0]       r_cnt_p1;
  logic             r_vld_p1;
  logic [3:0]       r_anode;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [6:0]       w_seg_dec;
  logic             w_tick;

  assign w_tick = (r_pre == PRE_LAST);

  seg_decoder u_dec (
    .i_nib (char),
    .o_seg (w_seg_dec)
  );

  // Stage p0: prescaler and scan counter driven to the character generator
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre    <= '0;
      r_cnt_p0 <= 4'd0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_cnt_p0 <= r_cnt_p0 + 4'd1;
    end
  end

  // Stage p1: counter delayed to line up with the returning char
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt_p1 <= 4'd0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_cnt_p1 <= r_cnt_p0;
      r_vld_p1 <= 1'b1;
    end
  end

  // Stage p2: anode and segments registered together; blank until char is trustworthy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_anode <= ANODE_OFF;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
    end else begin
      r_dp <= 1'b1;
      if (!r_vld_p1 || phase_of(r_cnt_p1) == PH_GUARD) begin
        r_anode <= ANODE_OFF;
        r_seg   <= SEG_BLANK;
      end else begin
        r_anode <= anode_sel(r_cnt_p1[3:2]);
        r_seg   <= w_seg_dec;
      end
    end
  end

  assign counter = r_cnt_p0;
  assign anode   = r_anode;
  assign seg     = r_seg;
  assign dp      = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver at PRESCALE=4 and PRESCALE=1, with a
// registered character-generator model and a time-based reference model.
module tb_seg_scan_driver;

  localparam int P0 = 4;
  localparam int P1 = 1;

  typedef struct packed {
    logic [3:0] cnt;
    logic [3:0] an;
    logic [6:0] sg;
  } exp_t;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] rst_n;
  logic [1:0] rst_req;
  logic [1:0] frc;
  logic [1:0] drand;
  logic [3:0] chr   [2];
  logic [3:0] cnt   [2];
  logic [3:0] anode [2];
  logic [6:0] seg   [2];
  logic       dp    [2];

  logic [7:0] data  [2];
  logic [7:0] dprev [2];
  logic [3:0] cprev [2];
  logic [3:0] fv    [2];
  int         t     [2];
  int         pval  [2];
  logic       last_active [2];
  logic [3:0] last_cnt    [2];

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.PRESCALE(P0)) dut0 (
    .clock   (clock),
    .reset   (rst_n[0]),
    .char    (chr[0]),
    .counter (cnt[0]),
    .anode   (anode[0]),
    .seg     (seg[0]),
    .dp      (dp[0])
  );

  seg_scan_driver #(.PRESCALE(P1)) dut1 (
    .clock   (clock),
    .reset   (rst_n[1]),
    .char    (chr[1]),
    .counter (cnt[1]),
    .anode   (anode[1]),
    .seg     (seg[1]),
    .dp      (dp[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (time %0t)", nm, act, req, $time);
    end
  endtask

  // Digits 3 and 1 show the high nibble of the byte, digits 2 and 0 the low nibble.
  function automatic logic [3:0] nib(input logic [7:0] d, input int c);
    return (((c / 4) % 2) == 0) ? d[7:4] : d[3:0];
  endfunction

  // Expected state after the tt-th rising edge since reset release.
  function automatic exp_t model(input int p, input int tt, input logic [7:0] d,
                                 input logic f, input logic [3:0] fvv);
    exp_t e;
    int c;
    e.cnt = 4'((tt / p) % 16);
    e.an  = 4'hF;
    e.sg  = 7'h7F;
    if (tt >= 2) begin
      c = ((tt - 2) / p) % 16;
      if ((c % 4) != 3) begin
        e.an[3 - (c / 4)] = 1'b0;
        e.sg = segtab[f ? fvv : nib(d, c)];
      end
    end
    return e;
  endfunction

  task automatic step();
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (rst_req[i] && rst_n[i]) begin
        rst_n[i] = 1'b0;
        #1;
        chk($sformatf("d%0d_async_cnt", i), 32'(cnt[i]), 32'h0);
        chk($sformatf("d%0d_async_anode", i), 32'(anode[i]), 32'hF);
        chk($sformatf("d%0d_async_seg", i), 32'(seg[i]), 32'h7F);
      end
      rst_n[i] = !rst_req[i];
      t[i] = rst_n[i] ? t[i] + 1 : 0;
      if (drand[i] && $urandom_range(15) == 0) data[i] = 8'($urandom);
      chr[i] = frc[i] ? fv[i] : nib(dprev[i], int'(cprev[i]));
      e = model(pval[i], t[i], dprev[i], frc[i], chr[i]);
      cprev[i] = cnt[i];
      dprev[i] = data[i];
      last_active[i] = (e.an != 4'hF);
      last_cnt[i] = e.cnt;
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  initial begin
    @(negedge clock);
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        logic have;
        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
          chk($sformatf("d%0d_queue_empty", i), 32'h1, 32'h0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("d%0d_counter", i), 32'(cnt[i]), 32'(e.cnt));
          chk($sformatf("d%0d_anode", i), 32'(anode[i]), 32'(e.an));
          chk($sformatf("d%0d_seg", i), 32'(seg[i]), 32'(e.sg));
        end
        chk($sformatf("d%0d_dp", i), 32'(dp[i]), 32'h1);
        chk($sformatf("d%0d_anode_legal", i),
            32'(anode[i] inside {4'hF, 4'h7, 4'hB, 4'hD, 4'hE}), 32'h1);
        chk($sformatf("d%0d_blank_aligned", i),
            32'(anode[i] == 4'hF), 32'(seg[i] == 7'h7F));
      end
    end
  end

  initial begin
    int sw;
    logic found;
    rst_n   = 2'b00;
    rst_req = 2'b11;
    frc     = 2'b00;
    drand   = 2'b00;
    pval[0] = P0;
    pval[1] = P1;
    data[0] = 8'hA5;
    data[1] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      dprev[i] = data[i];
      cprev[i] = 4'd0;
      fv[i]    = 4'd0;
      chr[i]   = 4'd0;
      t[i]     = 0;
      last_active[i] = 1'b0;
      last_cnt[i]    = 4'd0;
    end

    repeat (5) step();
    rst_req = 2'b00;
    repeat (64) step();
    drand = 2'b11;
    repeat (128) step();

    drand  = 2'b00;
    frc[0] = 1'b1;
    sw = 0;
    for (int g = 0; g < 200 && sw < 16; g++) begin
      fv[0] = 4'(sw);
      step();
      if (last_active[0]) sw++;
    end
    chk("sweep_complete", 32'(sw), 32'd16);

    frc = 2'b10;
    for (int k = 0; k < 40; k++) begin
      fv[1] = 4'($urandom);
      step();
    end
    frc   = 2'b00;
    drand = 2'b11;

    found = 1'b0;
    for (int g = 0; g < 100 && !found; g++) begin
      step();
      if (last_cnt[0] == 4'd5) found = 1'b1;
    end
    chk("reached_counter5", 32'(found), 32'h1);
    rst_req[0] = 1'b1;
    repeat (2) step();
    rst_req[0] = 1'b0;
    repeat (80) step();

    @(posedge clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
